// File: rtl/booth_pkg.sv
// Shared types and the {Q0, Q-1} decode for the radix-2 Booth multiplier controller.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } booth_state_e;

  typedef enum logic [1:0] {
    BOOTH_NOP,
    BOOTH_ADD,
    BOOTH_SUB
  } booth_op_e;

  function automatic booth_op_e booth_decode(input logic [1:0] q_pair);
    booth_op_e op;
    case (q_pair)
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_controller_if.sv
// Request/result handshake between a multiply requester (master) and booth_controller (slave).
interface booth_controller_if;
  logic start_valid;
  logic start_ready;
  logic mcand_zero;
  logic mplier_zero;
  logic res_valid;
  logic res_zero;
  logic res_ready;

  modport master (
    output start_valid, mcand_zero, mplier_zero, res_ready,
    input  start_ready, res_valid, res_zero
  );

  modport slave (
    input  start_valid, mcand_zero, mplier_zero, res_ready,
    output start_ready, res_valid, res_zero
  );
endinterface

// File: rtl/booth_iter_counter.sv
// Booth iteration counter: synchronous clear, enable, and combinational terminal flag at WIDTH-1.
module booth_iter_counter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             term_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count_o = count_q;
  assign term_o  = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/booth_controller.sv
// Radix-2 Booth multiplier sequencer: IDLE -> CALC (WIDTH iterations) -> DONE.
// Optional macro BOOTH_ZERO_SKIP_EN: zero operand at request goes straight to DONE with res_zero.
module booth_controller
  import booth_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  booth_controller_if.slave   req,
  input  logic [1:0]          q_pair_i,
  output logic                load_o,
  output logic                alu_en_o,
  output logic                alu_sub_o,
  output logic                shift_en_o,
  output logic [CNT_W-1:0]    count_o,
  output logic                busy_o
);

  booth_state_e state_q;
  logic         start_ready_q;
  logic         busy_q;
  logic         res_valid_q;
  logic         shift_en_q;
  logic         accept;
  logic         res_take;
  logic         in_calc;
  logic         term;
  logic         cnt_clear;
  logic         cnt_en;
  logic         skip;
  booth_op_e    op;

  // Reset wins over a same-cycle handshake so the datapath never sees a stray load.
  assign accept   = start_ready_q & req.start_valid & ~reset;
  assign res_take = res_valid_q & req.res_ready;
  assign in_calc  = (state_q == CALC);
  assign op       = booth_decode(q_pair_i);

`ifdef BOOTH_ZERO_SKIP_EN
  logic res_zero_q;
  assign skip         = req.mcand_zero | req.mplier_zero;
  assign req.res_zero = res_zero_q;
`else
  logic unused_zero_flags;
  assign unused_zero_flags = req.mcand_zero | req.mplier_zero;
  assign skip              = 1'b0;
  assign req.res_zero      = 1'b0;
`endif

  assign cnt_clear = reset | accept | ((state_q == DONE) & res_take);
  assign cnt_en    = in_calc & ~term;

  booth_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .clear_i (cnt_clear),
    .en_i    (cnt_en),
    .count_o (count_o),
    .term_o  (term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      shift_en_q    <= 1'b0;
`ifdef BOOTH_ZERO_SKIP_EN
      res_zero_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            if (skip) begin
              state_q     <= DONE;
              res_valid_q <= 1'b1;
`ifdef BOOTH_ZERO_SKIP_EN
              res_zero_q  <= 1'b1;
`endif
            end else begin
              state_q    <= CALC;
              shift_en_q <= 1'b1;
            end
          end
        end
        CALC: begin
          if (term) begin
            state_q     <= DONE;
            shift_en_q  <= 1'b0;
            res_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (res_take) begin
            state_q       <= IDLE;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            res_valid_q   <= 1'b0;
`ifdef BOOTH_ZERO_SKIP_EN
            res_zero_q    <= 1'b0;
`endif
          end
        end
        default: begin
          state_q       <= IDLE;
          start_ready_q <= 1'b1;
          busy_q        <= 1'b0;
          res_valid_q   <= 1'b0;
          shift_en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign req.start_ready = start_ready_q;
  assign req.res_valid   = res_valid_q;
  assign busy_o          = busy_q;
  assign shift_en_o      = shift_en_q;
  assign load_o          = accept;
  assign alu_en_o        = in_calc & (op != BOOTH_NOP);
  assign alu_sub_o       = in_calc & (op == BOOTH_SUB);

endmodule

// File: tb/tb_booth_controller.sv
// Scoreboard bench for booth_controller: issue-time expectations, cycle-level reference model.
module tb_booth_controller;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;
`ifdef BOOTH_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  booth_controller_if bus();
  logic [1:0]       q_pair;
  logic             load, alu_en, alu_sub, shift_en, busy;
  logic [CNT_W-1:0] count;

  booth_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (bus),
    .q_pair_i   (q_pair),
    .load_o     (load),
    .alu_en_o   (alu_en),
    .alu_sub_o  (alu_sub),
    .shift_en_o (shift_en),
    .count_o    (count),
    .busy_o     (busy)
  );

  typedef struct {
    int lat;
    bit zero;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  bit         q_dir   = 1'b0;
  logic [1:0] q_val   = 2'b00;
  bit         rr_force = 1'b0;
  logic       rr_val   = 1'b0;

  // Background drivers for q_pair and res_ready (directed values override)
  initial begin
    q_pair        = 2'b00;
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      q_pair        = q_dir ? q_val : 2'($urandom);
      bus.res_ready = rr_force ? rr_val : 1'($urandom);
    end
  end

  // Reference model + monitor
  bit   m_active = 1'b0;
  bit   m_skip   = 1'b0;
  int   m_hs     = 0;
  int   m_first  = -1;
  int   cyc      = 0;

  initial begin
    logic e_sr, e_ld, e_bz, e_rv, e_rz, e_sh, e_ae, e_as;
    bit   calc;
    int   k, e_cnt;
    logic [11:0] exp_v, act_v;
    exp_t it;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      if (!m_active) begin
        e_sr = 1'b1; e_ld = bus.start_valid && !reset; e_bz = 1'b0; e_rv = 1'b0;
        e_rz = 1'b0; e_sh = 1'b0; e_ae = 1'b0; e_as = 1'b0; e_cnt = 0;
      end else begin
        k     = cyc - m_hs;
        calc  = !m_skip && (k <= WIDTH);
        e_rv  = (k >= (m_skip ? 1 : WIDTH + 1));
        e_cnt = m_skip ? 0 : (calc ? k - 1 : WIDTH - 1);
        e_sh  = calc;
        e_ae  = calc && (q_pair == 2'b01 || q_pair == 2'b10);
        e_as  = calc && (q_pair == 2'b10);
        e_bz  = 1'b1;
        e_rz  = e_rv && m_skip;
        e_sr  = 1'b0;
        e_ld  = 1'b0;
      end
      exp_v = {e_sr, e_ld, e_bz, e_rv, e_rz, e_sh, e_ae, e_as, CNT_W'(e_cnt)};
      act_v = {bus.start_ready, load, busy, bus.res_valid, bus.res_zero,
               shift_en, alu_en, alu_sub, count};
      checks++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL ctrl cycle %0d {rdy,ld,busy,rv,rz,sh,ae,as,cnt}: got %03h expected %03h",
                 cyc, act_v, exp_v);
      end
      if (m_active && bus.res_valid === 1'b1 && m_first < 0) m_first = cyc;

      if (reset) begin
        m_active = 1'b0;
        exp_q.delete();
      end else if (!m_active) begin
        if (bus.start_valid) begin
          m_active = 1'b1;
          m_hs     = cyc;
          m_skip   = ZS && (bus.mcand_zero || bus.mplier_zero);
          m_first  = -1;
        end
      end else if (e_rv && bus.res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL result: got a product with no request outstanding");
        end else begin
          it = exp_q.pop_front();
          if ((m_first - m_hs) != it.lat || bus.res_zero !== it.zero) begin
            fails++;
            $display("FAIL result latency/zero: got lat=%0d zero=%b expected lat=%0d zero=%b",
                     m_first - m_hs, bus.res_zero, it.lat, it.zero);
          end
        end
        m_active = 1'b0;
      end
    end
  end

  task automatic wait_hs();
    bit ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.start_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL handshake timeout: got start_ready=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic issue(input logic mz, input logic pz);
    exp_t e;
    e.zero = ZS && (mz || pz);
    e.lat  = e.zero ? 1 : WIDTH + 1;
    exp_q.push_back(e);
    bus.mcand_zero  = mz;
    bus.mplier_zero = pz;
    bus.start_valid = 1'b1;
    wait_hs();
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    bus.mcand_zero  = 1'b0;
    bus.mplier_zero = 1'b0;
  endtask

  task automatic wait_result();
    bit ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.res_valid && bus.res_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL result timeout: got no res_valid&res_ready expected one within 300 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL valid timeout: got res_valid=0 expected 1 within 100 cycles");
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.start_valid = 1'b0;
    bus.mcand_zero  = 1'b0;
    bus.mplier_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed q_pair sequence, then a stalled result with the next request waiting
    rr_force = 1'b1;
    rr_val   = 1'b0;
    issue(1'b0, 1'b0);
    q_dir = 1'b1;
    q_val = 2'b10;
    @(posedge clk); #1; q_val = 2'b11;
    @(posedge clk); #1; q_val = 2'b01;
    @(posedge clk); #1; q_val = 2'b00;
    @(posedge clk); #1; q_dir = 1'b0;
    begin
      exp_t e;
      e.zero = 1'b0;
      e.lat  = WIDTH + 1;
      exp_q.push_back(e);
    end
    bus.start_valid = 1'b1;
    wait_valid();
    repeat (5) @(posedge clk);
    #1;
    rr_val = 1'b1;
    wait_hs();
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    rr_force = 1'b0;
    wait_result();

    // Reset while CALC is at count 7
    issue(1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (WIDTH + 4) @(posedge clk);
    #1;

    // Zero operands
    issue(1'b0, 1'b1);
    wait_result();
    issue(1'b1, 1'b0);
    wait_result();

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic z;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      z = ($urandom_range(0, 3) == 0);
      issue(z & 1'($urandom), z);
    end
    wait_result();
    repeat (4) @(posedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
